seq1010_framer_tx: RTL and testbench

- Serial transmitter for the "1010" sync-marker link; it drives the line that the overlapping Mealy 1010 detector monitors.
- Accepts a parallel word over a valid/ready handshake and emits a frame on one serial line: sync header 1010, then the payload MSB first.
- Bit-stuffing guarantees that the receiver sees 1010 exactly once per frame, at the header, with overlap considered.
- Idle line level is 0.

---
 rtl/seq1010_framer_tx.sv | 138 +++++++++++++
 tb/tb_seq1010_framer_tx.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/seq1010_framer_tx.sv
// seq1010_framer_tx: serial framer for the 1010 sync-marker link.
// Each frame is the header 1010 followed by the payload MSB first. A 1 is
// stuffed after any payload bit that leaves the last three line bits at 101,
// so the receiver's overlapping detector sees 1010 only at the header.
// Ser_Out, Busy and Stuff are registered from the next-state decode, so the
// first header bit appears one cycle after the accept edge.
module seq1010_framer_tx #(
  parameter int DATA_W   = 8,
  parameter int IDLE_GAP = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] Data_In,
  input  logic              Valid,
  output logic              Ready,
  output logic              Ser_Out,
  output logic              Busy,
  output logic              Stuff,
  output logic [2:0]        CS
);

  localparam int               REM_W    = $clog2(DATA_W + 1);
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(DATA_W);
  localparam logic [REM_W-1:0] REM_ONE  = REM_W'(1);
  localparam logic [3:0]       GAP_LAST = 4'(IDLE_GAP);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SYNC  = 3'd1,
    DATA  = 3'd2,
    STUFF = 3'd3,
    GAP   = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] sreg, sreg_nxt;   // payload bits still to send, MSB next
  logic [REM_W-1:0]  rem, rem_nxt;     // payload bits still to send
  logic [3:0]        cnt, cnt_nxt;     // header bit index / gap cycle count
  logic [2:0]        hist;             // last three bits put on the line
  logic              bit_nxt;
  logic              take_bit;
  logic              go_gap;

  assign Ready = (state == IDLE);
  assign CS    = state;

  // Next-state decode plus the line bit that the next state will carry.
  always_comb begin
    state_nxt = IDLE;
    bit_nxt   = 1'b0;
    sreg_nxt  = sreg;
    rem_nxt   = rem;
    cnt_nxt   = cnt;
    take_bit  = 1'b0;
    go_gap    = 1'b0;
    case (state)
      IDLE: begin
        if (Valid) begin
          state_nxt = SYNC;
          bit_nxt   = 1'b1;
          sreg_nxt  = Data_In;
          rem_nxt   = REM_INIT;
          cnt_nxt   = 4'd0;
        end
      end
      SYNC: begin
        if (cnt != 4'd3) begin
          // header is 1,0,1,0: the bit after index k is k[0]
          state_nxt = SYNC;
          bit_nxt   = cnt[0];
          cnt_nxt   = cnt + 4'd1;
        end else begin
          take_bit = 1'b1;
        end
      end
      DATA: begin
        // the line holds ...101; a 0 now would complete the marker
        if (hist == 3'b101) begin
          state_nxt = STUFF;
          bit_nxt   = 1'b1;
        end else if (rem != '0) begin
          take_bit = 1'b1;
        end else begin
          go_gap = 1'b1;
        end
      end
      STUFF: begin
        if (rem != '0) take_bit = 1'b1;
        else           go_gap   = 1'b1;
      end
      GAP: begin
        if (cnt != GAP_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = cnt + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (take_bit) begin
      state_nxt = DATA;
      bit_nxt   = sreg[DATA_W-1];
      sreg_nxt  = {sreg[DATA_W-2:0], 1'b0};
      rem_nxt   = rem - REM_ONE;
    end
    if (go_gap) begin
      state_nxt = GAP;
      cnt_nxt   = 4'd1;
    end
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Registered line outputs, payload shifter, counters and line history.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      Ser_Out <= 1'b0;
      Busy    <= 1'b0;
      Stuff   <= 1'b0;
      sreg    <= '0;
      rem     <= '0;
      cnt     <= 4'd0;
      hist    <= 3'b000;
    end else begin
      Ser_Out <= bit_nxt;
      Busy    <= (state_nxt != IDLE);
      Stuff   <= (state_nxt == STUFF);
      sreg    <= sreg_nxt;
      rem     <= rem_nxt;
      cnt     <= cnt_nxt;
      hist    <= {hist[1:0], bit_nxt};
    end
  end

endmodule

// File: tb/tb_seq1010_framer_tx.sv
// Directed bench for seq1010_framer_tx (DATA_W=8, IDLE_GAP=1).
// Line streams are collected MSB-first, one bit per cycle after the accept
// edge, and compared with hand-derived frames.
module tb_seq1010_framer_tx;

  logic       Clk = 1'b0;
  logic       Rst;
  logic [7:0] Data_In;
  logic       Valid;
  logic       Ready;
  logic       Ser_Out;
  logic       Busy;
  logic       Stuff;
  logic [2:0] CS;

  int n_run  = 0;
  int n_fail = 0;

  logic [31:0] ser, stf, bsy;

  always #5 Clk = ~Clk;

  seq1010_framer_tx #(.DATA_W(8), .IDLE_GAP(1)) dut (
    .Clk     (Clk),
    .Rst     (Rst),
    .Data_In (Data_In),
    .Valid   (Valid),
    .Ready   (Ready),
    .Ser_Out (Ser_Out),
    .Busy    (Busy),
    .Stuff   (Stuff),
    .CS      (CS)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference overlapping 1010 detector over the first n collected bits.
  function automatic int count1010(input logic [31:0] v, input int n);
    int c = 0;
    for (int i = n - 1; i >= 3; i--)
      if (v[i -: 4] == 4'b1010) c++;
    return c;
  endfunction

  // Called just after a falling edge with the DUT idle. Offers d0, switches
  // Data_In to d1 after the first line cycle, drops Valid after cycle drop_at
  // and records n line cycles.
  task automatic run_frame(input logic [7:0] d0, input logic [7:0] d1,
                           input int n, input int drop_at,
                           output logic [31:0] s, output logic [31:0] f,
                           output logic [31:0] b);
    s = '0; f = '0; b = '0;
    Data_In = d0;
    Valid   = 1'b1;
    @(posedge Clk);
    for (int i = 1; i <= n; i++) begin
      @(negedge Clk);
      s = {s[30:0], Ser_Out};
      f = {f[30:0], Stuff};
      b = {b[30:0], Busy};
      if (i == 1) Data_In = d1;
      if (i == drop_at) Valid = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    Rst     = 1'b1;
    Valid   = 1'b1;
    Data_In = 8'hFF;

    // reset held with Valid high
    for (int k = 0; k < 2; k++) begin
      @(posedge Clk);
      @(negedge Clk);
      chk("rst_ser",   32'(Ser_Out), 32'd0);
      chk("rst_busy",  32'(Busy),    32'd0);
      chk("rst_ready", 32'(Ready),   32'd1);
      chk("rst_cs",    32'(CS),      32'd0);
    end
    Rst   = 1'b0;
    Valid = 1'b0;
    @(negedge Clk);
    chk("post_rst_busy", 32'(Busy),    32'd0);
    chk("post_rst_ser",  32'(Ser_Out), 32'd0);

    // 0x00: no stuffing, 13 busy cycles, Ready back on cycle 14
    run_frame(8'h00, 8'h00, 14, 1, ser, stf, bsy);
    chk("x00_ser",   ser, 32'(14'b10100000000000));
    chk("x00_stuff", stf, 32'd0);
    chk("x00_busy",  bsy, 32'(14'b11111111111110));
    chk("x00_ready", 32'(Ready), 32'd1);

    // 0xA5: payload 1[1]01[1]00101[1]
    run_frame(8'hA5, 8'hA5, 17, 1, ser, stf, bsy);
    chk("xA5_ser",    ser, 32'(17'b1010_1101_1001_0110_0));
    chk("xA5_stuff",  stf, 32'(17'b0000_0100_1000_0010_0));
    chk("xA5_busy",   bsy, 32'(17'b1111_1111_1111_1111_0));
    chk("xA5_nstuff", 32'($countones(stf)), 32'd3);
    chk("xA5_det",    32'(count1010(ser, 17)), 32'd1);

    // 0xFF: one stuff after the first payload bit
    run_frame(8'hFF, 8'hFF, 15, 1, ser, stf, bsy);
    chk("xFF_ser",   ser, 32'(15'b1010_1111_1111_100));
    chk("xFF_stuff", stf, 32'(15'b0000_0100_0000_000));
    chk("xFF_busy",  bsy, 32'(15'b1111_1111_1111_110));
    chk("xFF_det",   32'(count1010(ser, 15)), 32'd1);

    // back-to-back 0x55 then 0x0F with Valid held high
    run_frame(8'h55, 8'h0F, 31, 18, ser, stf, bsy);
    chk("b2b_ser",   ser, 32'(31'b1010_0101_1011_0110_0101_0000_0111_100));
    chk("b2b_busy",  bsy, 32'(31'b1111_1111_1111_1111_0111_1111_1111_110));
    chk("b2b_stuff", stf, 32'(31'b0000_0000_1001_0010_0000_0000_0000_000));
    chk("b2b_det",   32'(count1010(ser, 31)), 32'd2);

    // reset during the 6th line cycle of a 0xA5 frame
    ser = '0;
    Data_In = 8'hA5;
    Valid   = 1'b1;
    @(posedge Clk);
    for (int i = 1; i <= 6; i++) begin
      @(negedge Clk);
      ser = {ser[30:0], Ser_Out};
      if (i == 1) Valid = 1'b0;
    end
    chk("mid_ser6",   ser, 32'(6'b101011));
    chk("mid_stuff6", 32'(Stuff), 32'd1);
    chk("mid_cs6",    32'(CS), 32'd3);
    Rst = 1'b1;
    @(negedge Clk);
    chk("mid_rst_ser",   32'(Ser_Out), 32'd0);
    chk("mid_rst_busy",  32'(Busy),    32'd0);
    chk("mid_rst_stuff", 32'(Stuff),   32'd0);
    chk("mid_rst_ready", 32'(Ready),   32'd1);
    Rst = 1'b0;

    run_frame(8'h00, 8'h00, 14, 1, ser, stf, bsy);
    chk("re_x00_ser",   ser, 32'(14'b10100000000000));
    chk("re_x00_stuff", stf, 32'd0);
    chk("re_x00_busy",  bsy, 32'(14'b11111111111110));

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
